sevenseg_scanner: RTL and testbench
===================================

// Module: sevenseg_scanner
// PURPOSE
//  Parametrised multiplexed 7-segment display driver; next generation of the debug 7-seg scan logic in the SoC top.
//  Scans NDIGITS hex digits onto shared segment lines, with a frame-synchronous shadow register (no tearing).
//  Adds PWM brightness, per-digit enable mask, decimal points and leading-zero blanking.
//  Sits on the clk domain; fed by Debug_Display output or core debug_output, drives board an/sev_out pins.
// PARAMETERS
//  NDIGITS    8     number of digits scanned; data width is 4*NDIGITS
//  DIV        1024  clk cycles per digit slot; must be a multiple of 2**BRIGHT_W and >= 2**BRIGHT_W
//  BRIGHT_W   4     brightness control width; each slot splits into 2**BRIGHT_W sub-periods of SUB=DIV>>BRIGHT_W cycles
//  ACTIVE_LOW 1     1: an and dp_out are active-low; 0: active-high (sev_out encoding is always active-low, see table)
// PORTS
//  clk         in   1           single system clock
//  Rst         in   1           synchronous, active-high reset
//  data        in   4*NDIGITS   hex nibbles; digit i = data[4i+3:4i], digit 0 rightmost
//  dp_in       in   NDIGITS     decimal point per digit, 1 = lit
//  digit_en    in   NDIGITS     1 = digit may be lit; 0 = anode held inactive for that slot
//  blank_lz    in   1           1 = blank leading zero digits
//  brightness  in   BRIGHT_W    on-time in sub-periods per slot (0 = dark)
//  an          out  NDIGITS     anode selects, at most one active
//  sev_out     out  7           segments {a,b,c,d,e,f,g}, 0 = lit
//  dp_out      out  1           decimal point of current digit
//  frame_done  out  1           one-cycle pulse when the last digit slot ends
// BEHAVIOUR
//  Reset (Rst=1 at posedge):
//   - prescaler=0, digit index=0, shadow data/dp/en=0.
//   - an=all inactive; sev_out=7'h7F; dp_out inactive; frame_done=0.
//   - Outputs take these values the cycle after the Rst edge and hold them while Rst=1.
//   - Rst asserted mid-frame aborts the scan; after release, scanning restarts at digit 0, cnt 0.
//  Prescaler cnt: 0..DIV-1, increments every cycle. At cnt==DIV-1: cnt->0, idx->idx+1, wrapping NDIGITS-1 -> 0.
//  Shadow registers: data, dp_in and digit_en load at the cycle where cnt==DIV-1 and idx==NDIGITS-1, i.e. at frame wrap.
//   The first frame after reset therefore shows shadow=0 ('0' on enabled digits).
//   Input changes mid-frame are never visible before the next frame.
//  Blanking: sub_idx = cnt / SUB. Digit idx is lit iff all of the following hold:
//   - sub_idx < brightness
//   - shadow digit_en[idx] = 1
//   - the digit is not blanked by blank_lz
//  A digit is blanked by blank_lz iff all of the following hold:
//   - blank_lz = 1
//   - idx != 0
//   - shadow nibbles idx..NDIGITS-1 are all zero
//  Digit 0 is never blanked.
//  Maximum brightness is (2**BRIGHT_W-1)/2**BRIGHT_W on-time. The last sub-period is always dark, giving the anti-ghosting gap.
//  Unlit slot: an all inactive, sev_out=7'h7F, dp_out inactive.
//  Encode 0-F as 01,4F,12,06,4C,24,20,0F,00,04,08,60,31,42,30,38 (hex, 7-bit).
//  All outputs are registered: an/sev_out/dp_out reflect the cnt/idx/shadow state of the previous cycle (1-cycle latency).
//   - Segment value and anode change in the same cycle.
//   - Never two anodes active simultaneously.
//  frame_done: registered, high for exactly the cycle after the cnt==DIV-1 && idx==NDIGITS-1 cycle.
//   One pulse per NDIGITS*DIV cycles, independent of brightness.
//  brightness and blank_lz are used live (not shadowed); a change takes effect at the next cycle's evaluation.
// TESTING
//  Params for the bench: NDIGITS=8, DIV=16, BRIGHT_W=2, so SUB=4 and a frame is 128 cycles.
//  1 Rst held 5 cycles -> an=8'hFF, sev_out=7'h7F, frame_done=0.
//    Release with brightness=3 -> an=8'hFE for cycles 1..12 after release, 8'hFF for cycles 13..16, then digit 1 slot.
//  2 data=32'h12345678, digit_en=8'hFF -> after first frame_done, digit-0 slot sev_out=7'h00 ('8'),
//    digit-7 slot sev_out=7'h4F ('1'), an[7]=0.
//  3 Change data to 32'hFFFFFFFF at digit-3 slot -> remaining slots of that frame unchanged;
//    next frame shows 7'h38 on all digits.
//  4 blank_lz=1, data=32'h00000050 -> digits 7..2 an inactive for whole slot; digit1 7'h24, digit0 7'h01;
//    data=0 -> only digit0 lit.
//  5 brightness=0 -> an=8'hFF for an entire frame; frame_done still pulses every 128 cycles.
//    digit_en=8'h01, dp_in=8'h01 -> only an[0] toggles; dp_out active with it.
//  6 Rst pulse during digit-5 slot -> next cycle reset values; after release, digit 0 first; frame_done 128 cycles later.

Source files
------------

// File: rtl/sevenseg_scanner.sv
// Multiplexed hex 7-segment scanner: shadowed frame data, PWM brightness,
// per-digit enable, decimal points and leading-zero blanking.
module sevenseg_scanner #(
    parameter int NDIGITS    = 8,
    parameter int DIV        = 1024,
    parameter int BRIGHT_W   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   Rst,
    input  logic [4*NDIGITS-1:0]   data,
    input  logic [NDIGITS-1:0]     dp_in,
    input  logic [NDIGITS-1:0]     digit_en,
    input  logic                   blank_lz,
    input  logic [BRIGHT_W-1:0]    brightness,
    output logic [NDIGITS-1:0]     an,
    output logic [6:0]             sev_out,
    output logic                   dp_out,
    output logic                   frame_done
);

    localparam int SUB   = DIV >> BRIGHT_W;
    localparam int SUB_W = (SUB > 1) ? $clog2(SUB) : 1;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'(SUB - 1);
    localparam logic [BRIGHT_W-1:0] SUB_IDX_LAST = {BRIGHT_W{1'b1}};
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NDIGITS - 1);
    localparam logic [NDIGITS-1:0]  AN_OFF   = (ACTIVE_LOW != 0) ? {NDIGITS{1'b1}} : {NDIGITS{1'b0}};
    localparam logic                DP_OFF   = (ACTIVE_LOW != 0);
    localparam logic [6:0]          SEG_OFF  = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h01;
            4'h1:    seg = 7'h4F;
            4'h2:    seg = 7'h12;
            4'h3:    seg = 7'h06;
            4'h4:    seg = 7'h4C;
            4'h5:    seg = 7'h24;
            4'h6:    seg = 7'h20;
            4'h7:    seg = 7'h0F;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h04;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h60;
            4'hC:    seg = 7'h31;
            4'hD:    seg = 7'h42;
            4'hE:    seg = 7'h30;
            4'hF:    seg = 7'h38;
            default: seg = SEG_OFF;
        endcase
        return seg;
    endfunction

    // The slot prescaler is split into a sub-period counter and a sub-period
    // index so that cnt/SUB never needs a divider.
    logic [SUB_W-1:0]      sub_cnt_q, sub_cnt_d;
    logic [BRIGHT_W-1:0]   sub_idx_q, sub_idx_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*NDIGITS-1:0]  shadow_data_q, shadow_data_d;
    logic [NDIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic [NDIGITS-1:0]    shadow_en_q, shadow_en_d;
    logic [NDIGITS-1:0]    an_q, an_d;
    logic [6:0]            sev_q, sev_d;
    logic                  dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_end_s;
    logic                  frame_end_s;
    logic [3:0]            nib_s;
    logic                  en_s;
    logic                  dp_sel_s;
    logic                  zero_run_s;
    logic                  lz_blank_s;
    logic [NDIGITS-1:0]    onehot_s;
    logic                  lit_s;

    assign slot_end_s  = (sub_cnt_q == SUB_LAST) && (sub_idx_q == SUB_IDX_LAST);
    assign frame_end_s = slot_end_s && (idx_q == IDX_LAST);

    // Prescaler, digit index and frame-synchronous shadow capture.
    always_comb begin
        sub_cnt_d     = sub_cnt_q;
        sub_idx_d     = sub_idx_q;
        idx_d         = idx_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        shadow_en_d   = shadow_en_q;
        if (sub_cnt_q == SUB_LAST) begin
            sub_cnt_d = {SUB_W{1'b0}};
            sub_idx_d = sub_idx_q + 1'b1;
        end else begin
            sub_cnt_d = sub_cnt_q + 1'b1;
        end
        if (slot_end_s) begin
            idx_d = (idx_q == IDX_LAST) ? {IDX_W{1'b0}} : idx_q + 1'b1;
        end else begin
            idx_d = idx_q;
        end
        if (frame_end_s) begin
            shadow_data_d = data;
            shadow_dp_d   = dp_in;
            shadow_en_d   = digit_en;
        end else begin
            shadow_data_d = shadow_data_q;
        end
    end

    // Select the current digit's shadow fields; scanning from the top digit
    // down tracks whether every nibble at or above it is zero.
    always_comb begin
        nib_s      = 4'h0;
        en_s       = 1'b0;
        dp_sel_s   = 1'b0;
        zero_run_s = 1'b1;
        lz_blank_s = 1'b0;
        onehot_s   = {NDIGITS{1'b0}};
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_run_s  = zero_run_s && (shadow_data_q[4*i +: 4] == 4'h0);
            onehot_s[i] = (idx_q == IDX_W'(i));
            nib_s       = onehot_s[i] ? shadow_data_q[4*i +: 4] : nib_s;
            en_s        = onehot_s[i] ? shadow_en_q[i] : en_s;
            dp_sel_s    = onehot_s[i] ? shadow_dp_q[i] : dp_sel_s;
            lz_blank_s  = onehot_s[i] ? (zero_run_s && (i != 0)) : lz_blank_s;
        end
    end

    // Output decode; the top sub-period can never satisfy sub_idx < brightness,
    // which keeps an anti-ghosting gap at the end of every slot.
    always_comb begin
        lit_s        = (sub_idx_q < brightness) && en_s && !(blank_lz && lz_blank_s);
        frame_done_d = frame_end_s;
        if (lit_s) begin
            an_d  = (ACTIVE_LOW != 0) ? ~onehot_s : onehot_s;
            sev_d = hex_to_seg(nib_s);
            dp_d  = dp_sel_s ? ~DP_OFF : DP_OFF;
        end else begin
            an_d  = AN_OFF;
            sev_d = SEG_OFF;
            dp_d  = DP_OFF;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (Rst) begin
            sub_cnt_q     <= {SUB_W{1'b0}};
            sub_idx_q     <= {BRIGHT_W{1'b0}};
            idx_q         <= {IDX_W{1'b0}};
            shadow_data_q <= {(4*NDIGITS){1'b0}};
            shadow_dp_q   <= {NDIGITS{1'b0}};
            shadow_en_q   <= {NDIGITS{1'b0}};
            an_q          <= AN_OFF;
            sev_q         <= SEG_OFF;
            dp_q          <= DP_OFF;
            frame_done_q  <= 1'b0;
        end else begin
            sub_cnt_q     <= sub_cnt_d;
            sub_idx_q     <= sub_idx_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_en_q   <= shadow_en_d;
            an_q          <= an_d;
            sev_q         <= sev_d;
            dp_q          <= dp_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign sev_out    = sev_q;
    assign dp_out     = dp_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sevenseg_scanner.sv
// Randomized bench for sevenseg_scanner (8 digits, 16 cycles/slot, 2-bit brightness)
// checked every cycle against a time-based reference model.
module tb_sevenseg_scanner;

    localparam int ND = 8;
    localparam int DV = 16;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          Rst;
    logic [31:0]   data;
    logic [7:0]    dp_in;
    logic [7:0]    digit_en;
    logic          blank_lz;
    logic [1:0]    brightness;
    logic [7:0]    an;
    logic [6:0]    sev_out;
    logic          dp_out;
    logic          frame_done;

    always #5 clk = ~clk;

    sevenseg_scanner #(.NDIGITS(ND), .DIV(DV), .BRIGHT_W(BW), .ACTIVE_LOW(1)) dut (
        .clk(clk), .Rst(Rst), .data(data), .dp_in(dp_in), .digit_en(digit_en),
        .blank_lz(blank_lz), .brightness(brightness), .an(an), .sev_out(sev_out),
        .dp_out(dp_out), .frame_done(frame_done)
    );

    int n_total = 0;
    int n_pass  = 0;
    int fd_seen = 0;

    logic [6:0] seg_tbl [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference model: time since reset release plus the frame-captured inputs.
    int          tick = 0;
    logic [31:0] sh_data = 32'h0;
    logic [7:0]  sh_dp = 8'h0;
    logic [7:0]  sh_en = 8'h0;
    logic [7:0]  exp_an;
    logic [6:0]  exp_sev;
    logic        exp_dp;
    logic        exp_fd;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (tick %0d, t=%0t)", tag, obs, exp, tick, $time);
    endtask

    task automatic model_step();
        int   c;
        int   d;
        logic bl;
        logic lit;
        if (Rst) begin
            exp_an = 8'hFF; exp_sev = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
            tick = 0; sh_data = 32'h0; sh_dp = 8'h0; sh_en = 8'h0;
        end else begin
            c   = tick % DV;
            d   = (tick / DV) % ND;
            bl  = blank_lz && (d != 0) && ((sh_data >> (4 * d)) == 32'h0);
            lit = ((c / (DV / 4)) < int'(brightness)) && sh_en[d] && !bl;
            exp_an  = lit ? ~(8'(1) << d) : 8'hFF;
            exp_sev = lit ? seg_tbl[sh_data[4*d +: 4]] : 7'h7F;
            exp_dp  = (lit && sh_dp[d]) ? 1'b0 : 1'b1;
            exp_fd  = (tick % (ND * DV)) == (ND * DV - 1);
            if (exp_fd) begin
                sh_data = data; sh_dp = dp_in; sh_en = digit_en;
            end
            tick++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            model_step();
            @(posedge clk);
            @(negedge clk);
            if (frame_done === 1'b1) fd_seen++;
            check_eq("an", 32'(an), 32'(exp_an));
            check_eq("sev_out", 32'(sev_out), 32'(exp_sev));
            check_eq("dp_out", 32'(dp_out), 32'(exp_dp));
            check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
        end
    endtask

    initial begin
        Rst = 1'b1; data = $urandom; dp_in = 8'($urandom); digit_en = 8'($urandom);
        blank_lz = 1'b0; brightness = 2'd3;
        @(negedge clk);
        run(5);

        // Release; first frame shows the zeroed shadow, then 12345678.
        Rst = 1'b0; data = 32'h12345678; digit_en = 8'hFF; dp_in = 8'h00;
        run(2 * ND * DV);

        // Mid-frame change at the digit-3 slot only appears next frame.
        run(3 * DV + 5);
        data = 32'hFFFFFFFF;
        run(ND * DV - (3 * DV + 5) + ND * DV);

        blank_lz = 1'b1; data = 32'h00000050;
        run(2 * ND * DV);
        data = 32'h0;
        run(2 * ND * DV);

        // Dark display still produces one frame_done per frame.
        blank_lz = 1'b0; brightness = 2'd0;
        run(ND * DV);
        fd_seen = 0;
        run(2 * ND * DV);
        check_eq("fd_count", 32'(fd_seen), 32'd2);

        brightness = 2'd3; digit_en = 8'h01; dp_in = 8'h01; data = $urandom;
        run(2 * ND * DV);

        // Reset pulse in the digit-5 slot restarts at digit 0.
        for (int k = 0; k < 2 * ND * DV && (tick % (ND * DV)) != 5 * DV + 7; k++) run(1);
        check_eq("reach_slot5", 32'(tick % (ND * DV)), 32'(5 * DV + 7));
        Rst = 1'b1;
        run(1);
        Rst = 1'b0; digit_en = 8'hFF;
        fd_seen = 0;
        run(ND * DV);
        check_eq("fd_after_rst", 32'(fd_seen), 32'd1);
        run(ND * DV);

        // Randomized traffic, biased toward leading zeros.
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 19) == 0) data = $urandom >> (4 * $urandom_range(0, 8));
            if ($urandom_range(0, 19) == 0) dp_in = 8'($urandom);
            if ($urandom_range(0, 19) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 9) == 0) brightness = 2'($urandom);
            if ($urandom_range(0, 29) == 0) blank_lz = 1'($urandom);
            Rst = ($urandom_range(0, 499) == 0);
            run(1);
        end
        Rst = 1'b0;
        run(ND * DV);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
